// File: rtl/iob_eth_tb_mem_ctrl_pkg.sv
// Shared definitions for the Ethernet testbench memory controller.
// Holds the FSM state encoding, the fixed AXI4 field values and a small
// helper used to classify AXI response codes.
package iob_eth_tb_mem_ctrl_pkg;

  localparam int unsigned STATE_W   = 3;
  localparam int unsigned ERR_CNT_W = 8;

  // FSM states
  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_W_ADDR = 3'd1;
  localparam logic [STATE_W-1:0] ST_W_DATA = 3'd2;
  localparam logic [STATE_W-1:0] ST_W_RESP = 3'd3;
  localparam logic [STATE_W-1:0] ST_R_ADDR = 3'd4;
  localparam logic [STATE_W-1:0] ST_R_DATA = 3'd5;
  localparam logic [STATE_W-1:0] ST_R_HOLD = 3'd6;

  // AXI4 constants
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'd2;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Any response other than OKAY counts as an error
  function automatic logic is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/iob_reg.sv
// Codebase register primitive: clock-enabled, asynchronously reset register.
// Ports: clk_i, cke_i (hold when low), arst_i (active-high async reset),
//        data_i (next value), data_o (registered value, RST_VAL on reset).
module iob_reg #(
  parameter int unsigned          DATA_W  = 1,
  parameter logic [DATA_W-1:0]    RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_o <= RST_VAL;
    end else if (cke_i) begin
      data_o <= data_i;
    end
  end

endmodule

// File: rtl/iob_eth_tb_mem_ctrl.sv
// Bridges the Ethernet testbench word-access port to a single-beat AXI4
// manager on the shared frame-buffer interconnect. One transaction at most is
// outstanding; a simultaneous write and read request is resolved write-first.
// Ports:
//   clk_i, cke_i, arst_i              clock, clock enable, async reset (high)
//   tb_addr_i, tb_aw*/tb_w*/tb_ar*/tb_r*   testbench request/response port
//   axi_aw*/axi_w*/axi_b*/axi_ar*/axi_r*   AXI4 manager port
//   err_cnt_o, err_o                  only with IOB_ETH_TB_MEM_CTRL_ERR_EN:
//                                     saturating non-OKAY response count and
//                                     sticky error flag
module iob_eth_tb_mem_ctrl
  import iob_eth_tb_mem_ctrl_pkg::*;
#(
  parameter int unsigned AXI_ID_W   = 1,
  parameter int unsigned AXI_ADDR_W = 12,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned AXI_LEN_W  = 8
) (
  input  logic                      clk_i,
  input  logic                      cke_i,
  input  logic                      arst_i,
  input  logic [AXI_ADDR_W-1:0]     tb_addr_i,
  input  logic                      tb_awvalid_i,
  output logic                      tb_awready_o,
  input  logic [AXI_DATA_W-1:0]     tb_wdata_i,
  input  logic                      tb_wvalid_i,
  output logic                      tb_wready_o,
  input  logic                      tb_arvalid_i,
  output logic                      tb_arready_o,
  output logic [AXI_DATA_W-1:0]     tb_rdata_o,
  output logic                      tb_rvalid_o,
  input  logic                      tb_rready_i,
  output logic [AXI_ID_W-1:0]       axi_awid_o,
  output logic [AXI_ADDR_W-1:0]     axi_awaddr_o,
  output logic [AXI_LEN_W-1:0]      axi_awlen_o,
  output logic [2:0]                axi_awsize_o,
  output logic [1:0]                axi_awburst_o,
  output logic                      axi_awvalid_o,
  input  logic                      axi_awready_i,
  output logic [AXI_DATA_W-1:0]     axi_wdata_o,
  output logic [AXI_DATA_W/8-1:0]   axi_wstrb_o,
  output logic                      axi_wlast_o,
  output logic                      axi_wvalid_o,
  input  logic                      axi_wready_i,
  input  logic [AXI_ID_W-1:0]       axi_bid_i,
  input  logic [1:0]                axi_bresp_i,
  input  logic                      axi_bvalid_i,
  output logic                      axi_bready_o,
  output logic [AXI_ID_W-1:0]       axi_arid_o,
  output logic [AXI_ADDR_W-1:0]     axi_araddr_o,
  output logic [AXI_LEN_W-1:0]      axi_arlen_o,
  output logic [2:0]                axi_arsize_o,
  output logic [1:0]                axi_arburst_o,
  output logic                      axi_arvalid_o,
  input  logic                      axi_arready_i,
  input  logic [AXI_ID_W-1:0]       axi_rid_i,
  input  logic [AXI_DATA_W-1:0]     axi_rdata_i,
  input  logic [1:0]                axi_rresp_i,
  input  logic                      axi_rlast_i,
  input  logic                      axi_rvalid_i,
`ifdef IOB_ETH_TB_MEM_CTRL_ERR_EN
  output logic [ERR_CNT_W-1:0]      err_cnt_o,
  output logic                      err_o,
`endif
  output logic                      axi_rready_o
);

  logic [STATE_W-1:0]    state;
  logic [STATE_W-1:0]    state_nxt;
  logic [AXI_ADDR_W-1:0] addr_q;
  logic [AXI_ADDR_W-1:0] addr_nxt;
  logic [AXI_DATA_W-1:0] rdata_nxt;
  logic                  addr_en;
  logic                  rdata_en;

  // State, latched address and read data registers
  iob_reg #(.DATA_W(STATE_W), .RST_VAL(ST_IDLE)) state_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
    .data_i(state_nxt), .data_o(state)
  );

  iob_reg #(.DATA_W(AXI_ADDR_W), .RST_VAL('0)) addr_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
    .data_i(addr_nxt), .data_o(addr_q)
  );

  iob_reg #(.DATA_W(AXI_DATA_W), .RST_VAL('0)) rdata_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
    .data_i(rdata_nxt), .data_o(tb_rdata_o)
  );

  // Word-align the request address; byte lanes are always all-enabled
  assign addr_nxt  = addr_en ? {tb_addr_i[AXI_ADDR_W-1:2], 2'b00} : addr_q;
  assign rdata_nxt = rdata_en ? axi_rdata_i : tb_rdata_o;

  // Fixed single-beat, 4-byte INCR transaction attributes
  assign axi_awid_o    = '0;
  assign axi_awaddr_o  = addr_q;
  assign axi_awlen_o   = '0;
  assign axi_awsize_o  = SIZE_4B;
  assign axi_awburst_o = BURST_INCR;
  assign axi_wstrb_o   = '1;
  assign axi_wlast_o   = 1'b1;
  assign axi_arid_o    = '0;
  assign axi_araddr_o  = addr_q;
  assign axi_arlen_o   = '0;
  assign axi_arsize_o  = SIZE_4B;
  assign axi_arburst_o = BURST_INCR;

  // Next-state and handshake decode. Readies are qualified with cke_i so no
  // handshake completes on a cycle where the state cannot advance.
  always_comb begin
    state_nxt     = state;
    addr_en       = 1'b0;
    rdata_en      = 1'b0;
    tb_awready_o  = 1'b0;
    tb_arready_o  = 1'b0;
    tb_wready_o   = 1'b0;
    tb_rvalid_o   = 1'b0;
    axi_awvalid_o = 1'b0;
    axi_wvalid_o  = 1'b0;
    axi_wdata_o   = '0;
    axi_bready_o  = 1'b0;
    axi_arvalid_o = 1'b0;
    axi_rready_o  = 1'b0;
    case (state)
      ST_IDLE: begin
        tb_awready_o = cke_i & tb_awvalid_i;
        tb_arready_o = cke_i & tb_arvalid_i & ~tb_awvalid_i;
        if (cke_i && tb_awvalid_i) begin
          addr_en   = 1'b1;
          state_nxt = ST_W_ADDR;
        end else if (cke_i && tb_arvalid_i) begin
          addr_en   = 1'b1;
          state_nxt = ST_R_ADDR;
        end
      end
      ST_W_ADDR: begin
        axi_awvalid_o = 1'b1;
        if (axi_awready_i) state_nxt = ST_W_DATA;
      end
      ST_W_DATA: begin
        axi_wvalid_o = tb_wvalid_i;
        axi_wdata_o  = tb_wdata_i;
        tb_wready_o  = cke_i & axi_wready_i;
        if (tb_wvalid_i && axi_wready_i) state_nxt = ST_W_RESP;
      end
      ST_W_RESP: begin
        axi_bready_o = cke_i;
        if (axi_bvalid_i) state_nxt = ST_IDLE;
      end
      ST_R_ADDR: begin
        axi_arvalid_o = 1'b1;
        if (axi_arready_i) state_nxt = ST_R_DATA;
      end
      ST_R_DATA: begin
        axi_rready_o = cke_i;
        if (axi_rvalid_i) begin
          rdata_en  = 1'b1;
          state_nxt = ST_R_HOLD;
        end
      end
      ST_R_HOLD: begin
        tb_rvalid_o = 1'b1;
        if (tb_rready_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef IOB_ETH_TB_MEM_CTRL_ERR_EN
  logic                 err_ev;
  logic [ERR_CNT_W-1:0] err_cnt_nxt;
  logic                 err_nxt;

  // Only one response channel can be active in a given state
  assign err_ev = ((state == ST_W_RESP) && axi_bvalid_i && is_err(axi_bresp_i)) ||
                  ((state == ST_R_DATA) && axi_rvalid_i && is_err(axi_rresp_i));
  assign err_cnt_nxt = (err_ev && (err_cnt_o != '1)) ? err_cnt_o + ERR_CNT_W'(1) : err_cnt_o;
  assign err_nxt     = err_o | err_ev;

  iob_reg #(.DATA_W(ERR_CNT_W), .RST_VAL('0)) err_cnt_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
    .data_i(err_cnt_nxt), .data_o(err_cnt_o)
  );

  iob_reg #(.DATA_W(1), .RST_VAL(1'b0)) err_reg (
    .clk_i(clk_i), .cke_i(cke_i), .arst_i(arst_i),
    .data_i(err_nxt), .data_o(err_o)
  );

  logic unused_sig;
  assign unused_sig = ^{tb_addr_i[1:0], axi_bid_i, axi_rid_i, axi_rlast_i};
`else
  logic unused_sig;
  assign unused_sig = ^{tb_addr_i[1:0], axi_bid_i, axi_rid_i, axi_rlast_i,
                        axi_bresp_i, axi_rresp_i};
`endif

endmodule

// File: tb/tb_iob_eth_tb_mem_ctrl.sv
// Self-checking bench for iob_eth_tb_mem_ctrl with a small AXI4 slave model.
// Expected write beats and read data are queued when requests are issued and
// compared when the DUT produces them. Build with IOB_ETH_TB_MEM_CTRL_ERR_EN
// defined to also exercise the error counter.
module tb_iob_eth_tb_mem_ctrl;

  logic        clk;
  logic        cke;
  logic        arst;
  logic [11:0] tb_addr;
  logic        tb_awvalid, tb_awready;
  logic [31:0] tb_wdata;
  logic        tb_wvalid, tb_wready;
  logic        tb_arvalid, tb_arready;
  logic [31:0] tb_rdata;
  logic        tb_rvalid, tb_rready;
  logic [0:0]  axi_awid;
  logic [11:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_awvalid, axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wlast, axi_wvalid, axi_wready;
  logic [0:0]  axi_bid;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid, axi_bready;
  logic [0:0]  axi_arid;
  logic [11:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_arvalid, axi_arready;
  logic [0:0]  axi_rid;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rlast, axi_rvalid, axi_rready;
`ifdef IOB_ETH_TB_MEM_CTRL_ERR_EN
  logic [7:0]  err_cnt;
  logic        err;
`endif

  iob_eth_tb_mem_ctrl dut (
    .clk_i(clk), .cke_i(cke), .arst_i(arst),
    .tb_addr_i(tb_addr),
    .tb_awvalid_i(tb_awvalid), .tb_awready_o(tb_awready),
    .tb_wdata_i(tb_wdata), .tb_wvalid_i(tb_wvalid), .tb_wready_o(tb_wready),
    .tb_arvalid_i(tb_arvalid), .tb_arready_o(tb_arready),
    .tb_rdata_o(tb_rdata), .tb_rvalid_o(tb_rvalid), .tb_rready_i(tb_rready),
    .axi_awid_o(axi_awid), .axi_awaddr_o(axi_awaddr), .axi_awlen_o(axi_awlen),
    .axi_awsize_o(axi_awsize), .axi_awburst_o(axi_awburst),
    .axi_awvalid_o(axi_awvalid), .axi_awready_i(axi_awready),
    .axi_wdata_o(axi_wdata), .axi_wstrb_o(axi_wstrb), .axi_wlast_o(axi_wlast),
    .axi_wvalid_o(axi_wvalid), .axi_wready_i(axi_wready),
    .axi_bid_i(axi_bid), .axi_bresp_i(axi_bresp), .axi_bvalid_i(axi_bvalid),
    .axi_bready_o(axi_bready),
    .axi_arid_o(axi_arid), .axi_araddr_o(axi_araddr), .axi_arlen_o(axi_arlen),
    .axi_arsize_o(axi_arsize), .axi_arburst_o(axi_arburst),
    .axi_arvalid_o(axi_arvalid), .axi_arready_i(axi_arready),
    .axi_rid_i(axi_rid), .axi_rdata_i(axi_rdata), .axi_rresp_i(axi_rresp),
    .axi_rlast_i(axi_rlast), .axi_rvalid_i(axi_rvalid),
`ifdef IOB_ETH_TB_MEM_CTRL_ERR_EN
    .err_cnt_o(err_cnt), .err_o(err),
`endif
    .axi_rready_o(axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr = 0;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wexp_t;

  wexp_t       exp_w[$];
  logic [31:0] exp_r[$];
  logic [31:0] model [logic [9:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- AXI4 slave model ----------------
  int          aw_delay;
  int          r_delay;
  logic [1:0]  b_resp_cfg;
  int          aw_cnt;
  int          r_cnt;
  bit          r_wait;
  logic [11:0] aw_addr_cap;
  logic [11:0] r_addr;
  logic [31:0] mem [0:1023];

  assign axi_awready = axi_awvalid && (aw_cnt >= aw_delay);
  assign axi_arready = axi_arvalid;
  assign axi_wready  = 1'b1;
  assign axi_bid     = '0;
  assign axi_rid     = '0;
  assign axi_rresp   = 2'b00;
  assign axi_rlast   = 1'b1;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      aw_cnt      <= 0;
      r_cnt       <= 0;
      r_wait      <= 1'b0;
      aw_addr_cap <= '0;
      r_addr      <= '0;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= 2'b00;
      axi_rvalid  <= 1'b0;
      axi_rdata   <= '0;
    end else begin
      if (axi_awvalid && !axi_awready) aw_cnt <= aw_cnt + 1;
      else aw_cnt <= 0;
      if (axi_awvalid && axi_awready) aw_addr_cap <= axi_awaddr;
      if (axi_wvalid && axi_wready) begin
        mem[aw_addr_cap[11:2]] <= axi_wdata;
        axi_bvalid <= 1'b1;
        axi_bresp  <= b_resp_cfg;
      end else if (axi_bvalid && axi_bready) begin
        axi_bvalid <= 1'b0;
      end
      if (axi_arvalid && axi_arready) begin
        if (r_delay == 0) begin
          axi_rvalid <= 1'b1;
          axi_rdata  <= mem[axi_araddr[11:2]];
        end else begin
          r_wait <= 1'b1;
          r_cnt  <= r_delay;
          r_addr <= axi_araddr;
        end
      end else if (r_wait) begin
        if (r_cnt == 1) begin
          r_wait     <= 1'b0;
          axi_rvalid <= 1'b1;
          axi_rdata  <= mem[r_addr[11:2]];
        end
        r_cnt <= r_cnt - 1;
      end else if (axi_rvalid && axi_rready) begin
        axi_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- AXI write-side monitor ----------------
  logic [11:0] mon_aw;
  always begin
    @(negedge clk);
    #3;
    if (!arst) begin
      if (axi_awvalid && axi_awready) begin
        mon_aw = axi_awaddr;
        check("awlen", 32'(axi_awlen), 32'd0);
        check("awsize", 32'(axi_awsize), 32'd2);
        check("awburst", 32'(axi_awburst), 32'd1);
      end
      if (axi_arvalid && axi_arready) begin
        check("arlen", 32'(axi_arlen), 32'd0);
        check("arsize", 32'(axi_arsize), 32'd2);
        check("arburst", 32'(axi_arburst), 32'd1);
      end
      if (axi_wvalid && axi_wready) begin
        if (exp_w.size() == 0) begin
          check("w_unexpected", 32'd1, 32'd0);
        end else begin
          wexp_t e;
          e = exp_w.pop_front();
          check("awaddr", 32'(mon_aw), 32'(e.addr));
          check("wdata", axi_wdata, e.data);
          check("wstrb", 32'(axi_wstrb), 32'hF);
          check("wlast", 32'(axi_wlast), 32'd1);
        end
      end
    end
  end

  // ---------------- request tasks (called just after a negedge) ----------------
  function automatic logic busy();
    return axi_awvalid | axi_wvalid | axi_bready | axi_arvalid | axi_rready | tb_rvalid;
  endfunction

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, output int lat);
    bit          beat_next;
    bit          prev_aw_wait;
    logic [11:0] prev_awaddr;
    tb_addr    = a;
    tb_wdata   = d;
    tb_awvalid = 1'b1;
    tb_wvalid  = 1'b1;
    #1;
    for (int i = 0; i < 20 && !tb_awready; i++) begin
      @(negedge clk);
      #1;
    end
    check("aw_accept", 32'(tb_awready), 32'd1);
    exp_w.push_back('{addr: {a[11:2], 2'b00}, data: d});
    model[a[11:2]] = d;
    lat          = 0;
    beat_next    = 1'b0;
    prev_aw_wait = 1'b0;
    prev_awaddr  = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      tb_awvalid = 1'b0;
      if (beat_next) tb_wvalid = 1'b0;
      beat_next = 1'b0;
      #1;
      lat++;
      if (prev_aw_wait) begin
        check("awvalid_held", 32'(axi_awvalid), 32'd1);
        check("awaddr_stable", 32'(axi_awaddr), 32'(prev_awaddr));
      end
      prev_aw_wait = axi_awvalid && !axi_awready;
      prev_awaddr  = axi_awaddr;
      if (!busy()) break;
      check("ar_blocked_busy", 32'(tb_arready), 32'd0);
      if (tb_wvalid && tb_wready) beat_next = 1'b1;
    end
    tb_wvalid = 1'b0;
    check("wr_done", 32'(busy()), 32'd0);
  endtask

  task automatic do_read(input logic [11:0] a, output int lat, output int hold);
    bit got;
    tb_addr    = a;
    tb_arvalid = 1'b1;
    tb_rready  = 1'b1;
    #1;
    for (int i = 0; i < 20 && !tb_arready; i++) begin
      @(negedge clk);
      #1;
    end
    check("ar_accept", 32'(tb_arready), 32'd1);
    exp_r.push_back(model[a[11:2]]);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      tb_arvalid = 1'b0;
      #1;
      lat++;
      if (tb_rvalid) begin
        got = 1'b1;
        break;
      end
    end
    check("rvalid_seen", 32'(got), 32'd1);
    if (got) check("rdata", tb_rdata, exp_r.pop_front());
    hold = 0;
    for (int i = 0; i < 10 && tb_rvalid; i++) begin
      hold++;
      @(negedge clk);
      #1;
    end
    tb_rready = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_awready"}, 32'(tb_awready), 32'd0);
    check({tag, "_arready"}, 32'(tb_arready), 32'd0);
    check({tag, "_wready"}, 32'(tb_wready), 32'd0);
    check({tag, "_rvalid"}, 32'(tb_rvalid), 32'd0);
    check({tag, "_rdata"}, tb_rdata, 32'd0);
    check({tag, "_awvalid"}, 32'(axi_awvalid), 32'd0);
    check({tag, "_awaddr"}, 32'(axi_awaddr), 32'd0);
    check({tag, "_wvalid"}, 32'(axi_wvalid), 32'd0);
    check({tag, "_wdata"}, axi_wdata, 32'd0);
    check({tag, "_bready"}, 32'(axi_bready), 32'd0);
    check({tag, "_arvalid"}, 32'(axi_arvalid), 32'd0);
    check({tag, "_araddr"}, 32'(axi_araddr), 32'd0);
    check({tag, "_rready"}, 32'(axi_rready), 32'd0);
`ifdef IOB_ETH_TB_MEM_CTRL_ERR_EN
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", nchecks, nerr);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int hold;
    aw_delay   = 0;
    r_delay    = 0;
    b_resp_cfg = 2'b00;
    cke        = 1'b1;
    arst       = 1'b1;
    tb_addr    = '0;
    tb_awvalid = 1'b0;
    tb_wdata   = '0;
    tb_wvalid  = 1'b0;
    tb_arvalid = 1'b0;
    tb_rready  = 1'b0;
    repeat (3) @(negedge clk);
    arst = 1'b0;
    #1;
    check_idle("reset");

    // Basic write then read-back
    @(negedge clk);
    #1;
    do_write(12'h010, 32'hDEADBEEF, lat);
    check("wr_lat_min", 32'(lat), 32'd4);
    do_read(12'h010, lat, hold);
    check("rd_lat_min", 32'(lat), 32'd3);
    check("rd_hold_one", 32'(hold), 32'd1);

    // Unaligned address is word-aligned on AXI
    do_write(12'h013, 32'h12345678, lat);
    check("wr_unaligned_lat", 32'(lat), 32'd4);
    do_read(12'h012, lat, hold);
    check("rd_unaligned_lat", 32'(lat), 32'd3);

    // Simultaneous write and read requests: write wins, read follows
    tb_addr    = 12'h020;
    tb_wdata   = 32'hA5A50F0F;
    tb_awvalid = 1'b1;
    tb_wvalid  = 1'b1;
    tb_arvalid = 1'b1;
    #1;
    check("both_awready", 32'(tb_awready), 32'd1);
    check("both_arready", 32'(tb_arready), 32'd0);
    do_write(12'h020, 32'hA5A50F0F, lat);
    check("both_wr_lat", 32'(lat), 32'd4);
    check("both_ar_after", 32'(tb_arready), 32'd1);
    do_read(12'h020, lat, hold);
    check("both_rd_lat", 32'(lat), 32'd3);

    // Slow slave: delayed awready and rvalid
    aw_delay = 5;
    r_delay  = 3;
    do_write(12'h040, 32'hCAFEF00D, lat);
    check("slow_wr_lat", 32'(lat), 32'd9);
    do_read(12'h040, lat, hold);
    check("slow_rd_lat", 32'(lat), 32'd6);
    check("slow_rd_hold", 32'(hold), 32'd1);
    aw_delay = 0;
    r_delay  = 0;

`ifdef IOB_ETH_TB_MEM_CTRL_ERR_EN
    // Two SLVERR write responses
    b_resp_cfg = 2'b10;
    do_write(12'h080, 32'h00000001, lat);
    do_write(12'h084, 32'h00000002, lat);
    b_resp_cfg = 2'b00;
    check("err_cnt_two", 32'(err_cnt), 32'd2);
    check("err_sticky", 32'(err), 32'd1);
    do_write(12'h088, 32'h00000003, lat);
    check("err_cnt_okay", 32'(err_cnt), 32'd2);
`endif

    // Reset while waiting in R_DATA
    r_delay    = 10;
    tb_addr    = 12'h040;
    tb_arvalid = 1'b1;
    tb_rready  = 1'b1;
    #1;
    check("mid_ar_accept", 32'(tb_arready), 32'd1);
    @(negedge clk);
    tb_arvalid = 1'b0;
    #1;
    for (int i = 0; i < 20 && !axi_rready; i++) begin
      @(negedge clk);
      #1;
    end
    check("mid_in_rdata", 32'(axi_rready), 32'd1);
    arst      = 1'b1;
    tb_rready = 1'b0;
    #1;
    check_idle("mid_rst");
    @(negedge clk);
    arst    = 1'b0;
    r_delay = 0;
    #1;
    check_idle("post_rst");
    do_read(12'h040, lat, hold);
    check("post_rst_rd_lat", 32'(lat), 32'd3);

    check("exp_w_drained", 32'(exp_w.size()), 32'd0);
    check("exp_r_drained", 32'(exp_r.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
